// File: rtl/count_frame_tx_if.sv
// Stream and snapshot-request bundle between the dual event counter, the frame
// transmitter and the byte sink.
// master: frame transmitter side (takes counts/request/ready, drives the byte stream)
// slave : counter + sink side
interface count_frame_tx_if;
    logic [63:0] cnt0;
    logic [63:0] cnt1;
    logic        req;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        busy;
    logic        overrun;

    modport master (
        input  cnt0, cnt1, req, tx_ready,
        output tx_data, tx_valid, tx_last, busy, overrun
    );

    modport slave (
        output cnt0, cnt1, req, tx_ready,
        input  tx_data, tx_valid, tx_last, busy, overrun
    );
endinterface

// File: rtl/count_frame_tx.sv
// count_frame_tx: snapshots two 64-bit counts on request and streams them as a
// byte frame (header, Cnt0 x8, Cnt1 x8, optional checksum) over valid/ready.
// Optional feature macro: COUNT_FRAME_CSUM_EN appends an XOR checksum byte.
module count_frame_tx #(
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter bit         MSB_FIRST = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    count_frame_tx_if.master tx_if
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        C0,
`ifdef COUNT_FRAME_CSUM_EN
        C1,
        CSUM
`else
        C1
`endif
    } state_t;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [63:0] snap0_q, snap1_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q, tx_last_q, overrun_q;
`ifdef COUNT_FRAME_CSUM_EN
    logic [7:0]  csum_q;
`endif

    logic       hs, accept;
    logic [2:0] idx_d;

    // Byte k of a count in wire order.
    function automatic logic [7:0] byte_sel(input logic [63:0] v, input logic [2:0] k);
        logic [2:0] s;
        s = MSB_FIRST ? (3'd7 - k) : k;
        return v[{s, 3'b000} +: 8];
    endfunction

    assign hs     = tx_valid_q && tx_if.tx_ready;
    // A new frame may start from IDLE or exactly as the final byte leaves.
    assign accept = tx_if.req && ((state_q == IDLE) || (hs && tx_last_q));
    assign idx_d  = idx_q + 3'd1;

    // Frame sequencer: all stream outputs are registered and preloaded with the next byte.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            snap0_q    <= '0;
            snap1_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef COUNT_FRAME_CSUM_EN
            csum_q     <= '0;
`endif
        end else if (accept) begin
            snap0_q    <= tx_if.cnt0;
            snap1_q    <= tx_if.cnt1;
            state_q    <= HDR;
            idx_q      <= 3'd0;
            tx_data_q  <= HEADER;
            tx_valid_q <= 1'b1;
            tx_last_q  <= 1'b0;
`ifdef COUNT_FRAME_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            if (tx_if.req) overrun_q <= 1'b1;
            if (hs) begin
                case (state_q)
                    HDR: begin
                        state_q   <= C0;
                        idx_q     <= 3'd0;
                        tx_data_q <= byte_sel(snap0_q, 3'd0);
                    end
                    C0: begin
`ifdef COUNT_FRAME_CSUM_EN
                        csum_q <= csum_q ^ tx_data_q;
`endif
                        if (idx_q == 3'd7) begin
                            state_q   <= C1;
                            idx_q     <= 3'd0;
                            tx_data_q <= byte_sel(snap1_q, 3'd0);
                        end else begin
                            idx_q     <= idx_d;
                            tx_data_q <= byte_sel(snap0_q, idx_d);
                        end
                    end
                    C1: begin
`ifdef COUNT_FRAME_CSUM_EN
                        csum_q <= csum_q ^ tx_data_q;
`endif
                        if (idx_q == 3'd7) begin
                            idx_q <= 3'd0;
`ifdef COUNT_FRAME_CSUM_EN
                            // Checksum must include the byte leaving right now.
                            state_q   <= CSUM;
                            tx_data_q <= csum_q ^ tx_data_q;
                            tx_last_q <= 1'b1;
`else
                            state_q    <= IDLE;
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
`endif
                        end else begin
                            idx_q     <= idx_d;
                            tx_data_q <= byte_sel(snap1_q, idx_d);
`ifndef COUNT_FRAME_CSUM_EN
                            tx_last_q <= (idx_d == 3'd7);
`endif
                        end
                    end
`ifdef COUNT_FRAME_CSUM_EN
                    CSUM: begin
                        state_q    <= IDLE;
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign tx_if.tx_data  = tx_data_q;
    assign tx_if.tx_valid = tx_valid_q;
    assign tx_if.tx_last  = tx_last_q;
    assign tx_if.busy     = (state_q != IDLE);
    assign tx_if.overrun  = overrun_q;

endmodule

// File: tb/tb_count_frame_tx.sv
// Bench for count_frame_tx: LSB-first and MSB-first instances share stimulus;
// a queue-based frame model plus a table of hand-computed frames check them.
module tb_count_frame_tx;

`ifdef COUNT_FRAME_CSUM_EN
    localparam int NB = 18;
`else
    localparam int NB = 17;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req = 1'b0, ready = 1'b0;
    logic [63:0] c0 = '0, c1 = '0;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    count_frame_tx_if if0();
    count_frame_tx_if if1();
    assign if0.req = req;  assign if0.tx_ready = ready; assign if0.cnt0 = c0; assign if0.cnt1 = c1;
    assign if1.req = req;  assign if1.tx_ready = ready; assign if1.cnt0 = c0; assign if1.cnt1 = c1;

    count_frame_tx #(.HEADER(8'hA5), .MSB_FIRST(1'b0)) u_lsb (.clk_i(clk), .rst_i(rst), .tx_if(if0));
    count_frame_tx #(.HEADER(8'hA5), .MSB_FIRST(1'b1)) u_msb (.clk_i(clk), .rst_i(rst), .tx_if(if1));

    // ---------------- reference model: queues of pending {last, byte} ----------------
    logic [8:0] q0[$], q1[$];
    logic       m_ovr = 1'b0;

    task automatic push_frame(input logic [63:0] a, input logic [63:0] b);
        logic [7:0] x0, x1, cs;
        cs = 8'h00;
        q0.push_back({1'b0, 8'hA5}); q1.push_back({1'b0, 8'hA5});
        for (int k = 0; k < 16; k++) begin
            logic [63:0] v;
            logic        lst;
            v  = (k < 8) ? a : b;
            x0 = 8'((v >> (8 * (k % 8))) & 64'hFF);
            x1 = 8'((v >> (8 * (7 - (k % 8)))) & 64'hFF);
            cs = cs ^ x0;
            lst = (k == 15) && (NB == 17);
            q0.push_back({lst, x0}); q1.push_back({lst, x1});
        end
        if (NB == 18) begin
            q0.push_back({1'b1, cs}); q1.push_back({1'b1, cs});
        end
    endtask

    task automatic model_step();
        if (q0.size() != 0 && ready) begin
            void'(q0.pop_front()); void'(q1.pop_front());
        end
        if (req && q0.size() == 0) push_frame(c0, c1);
        else if (req) m_ovr = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic ev;
        ev = (q0.size() != 0);
        chk("valid_lsb", if0.tx_valid, ev);  chk("valid_msb", if1.tx_valid, ev);
        chk("busy_lsb", if0.busy, ev);       chk("busy_msb", if1.busy, ev);
        chk("ovr_lsb", if0.overrun, m_ovr);  chk("ovr_msb", if1.overrun, m_ovr);
        if (ev) begin
            chk("data_lsb", if0.tx_data, q0[0][7:0]); chk("data_msb", if1.tx_data, q1[0][7:0]);
            chk("last_lsb", if0.tx_last, q0[0][8]);   chk("last_msb", if1.tx_last, q1[0][8]);
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_data"}, {if1.tx_data, if0.tx_data}, 16'h0);
        chk({nm, "_valid"}, {if1.tx_valid, if0.tx_valid}, 2'b00);
        chk({nm, "_last"}, {if1.tx_last, if0.tx_last}, 2'b00);
        chk({nm, "_busy"}, {if1.busy, if0.busy}, 2'b00);
        chk({nm, "_ovr"}, {if1.overrun, if0.overrun}, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 1'b0; ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        q0.delete(); q1.delete(); m_ovr = 1'b0;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- frame table ----------------
    typedef struct {
        logic [63:0]  c0, c1;
        logic [135:0] e_lsb, e_msb;   // header + 16 count bytes, first byte in the top bits
        logic [7:0]   csum;
        bit           toggle, scramble;
    } vec_t;

    vec_t tbl[5];
    logic [7:0] got0[NB], got1[NB];
    logic       gl0[NB], gl1[NB];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{64'h0102030405060708, 64'h1,
                   136'hA5_0807060504030201_0100000000000000,
                   136'hA5_0102030405060708_0000000000000001, 8'h09, 1'b0, 1'b0};
        tbl[1] = tbl[0]; tbl[1].toggle = 1'b1;
        tbl[2] = tbl[0]; tbl[2].scramble = 1'b1;
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                   136'hA5_FFFFFFFFFFFFFFFF_0000000000000080,
                   136'hA5_FFFFFFFFFFFFFFFF_8000000000000000, 8'h80, 1'b1, 1'b1};
        tbl[4] = '{64'h0, 64'hDEAD_BEEF_CAFE_F00D,
                   136'hA5_0000000000000000_0DF0FECAEFBEADDE,
                   136'hA5_0000000000000000_DEADBEEFCAFEF00D, 8'hEB, 1'b0, 1'b0};

        // Table frames: single Req, stalls and live-count changes must not alter bytes.
        for (int e = 0; e < 5; e++) begin
            int n;
            logic       pstall;
            logic [7:0] pd0, pd1;
            do_reset();
            c0 = tbl[e].c0; c1 = tbl[e].c1; req = 1'b1; ready = 1'b1;
            cycle();
            req = 1'b0; n = 0; pstall = 1'b0; pd0 = 8'h0; pd1 = 8'h0;
            for (int cyc = 0; cyc < 100 && n < NB; cyc++) begin
                ready = tbl[e].toggle ? ((cyc % 2) == 0) : 1'b1;
                if (tbl[e].scramble) begin c0 = '0; c1 = {$urandom, $urandom}; end
                if (pstall) begin
                    chk("stall_hold_lsb", if0.tx_data, pd0);
                    chk("stall_hold_msb", if1.tx_data, pd1);
                end
                pstall = if0.tx_valid && !ready; pd0 = if0.tx_data; pd1 = if1.tx_data;
                if (if0.tx_valid && ready) begin
                    got0[n] = if0.tx_data; got1[n] = if1.tx_data;
                    gl0[n] = if0.tx_last;  gl1[n] = if1.tx_last;
                    n++;
                end
                cycle();
            end
            chk("frame_len", n, NB);
            for (int i = 0; i < n; i++) begin
                logic [7:0] x0, x1;
                if (i < 17) begin
                    x0 = tbl[e].e_lsb[135 - 8*i -: 8];
                    x1 = tbl[e].e_msb[135 - 8*i -: 8];
                end else begin
                    x0 = tbl[e].csum; x1 = tbl[e].csum;
                end
                chk($sformatf("tbl%0d_b%0d_lsb", e, i), got0[i], x0);
                chk($sformatf("tbl%0d_b%0d_msb", e, i), got1[i], x1);
                chk($sformatf("tbl%0d_last%0d", e, i), {gl1[i], gl0[i]}, (i == NB - 1) ? 2'b11 : 2'b00);
            end
            cycle();
            chk("idle_after_frame", {if1.tx_valid, if0.tx_valid, if0.busy}, 3'b000);
        end

        // Reset in the middle of C0 with the sink ready.
        do_reset();
        c0 = 64'h1111_2222_3333_4444; c1 = 64'h5555_6666_7777_8888; req = 1'b1; ready = 1'b1;
        cycle();
        req = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        #2 rst = 1'b1;
        #1;
        q0.delete(); q1.delete(); m_ovr = 1'b0;
        check_zero("midframe_rst");
        @(negedge clk);
        rst = 1'b0; req = 1'b1;
        cycle();
        req = 1'b0;
        chk("fresh_hdr", {if1.tx_data, if0.tx_data}, 16'hA5A5);
        for (int i = 0; i < NB + 2; i++) cycle();

        // Req held high: back-to-back frames, no bubble, Overrun on first refusal.
        do_reset();
        begin
            int lows;
            lows = 0;
            c0 = 64'hABCD; c1 = 64'h1234; req = 1'b1; ready = 1'b1;
            cycle();
            chk("b2b_ovr_first", if0.overrun, 1'b0);
            cycle();
            chk("b2b_ovr_second", if0.overrun, 1'b1);
            for (int i = 0; i < 4 * NB; i++) begin
                c0 = {$urandom, $urandom};
                cycle();
                if (!if0.tx_valid) lows++;
            end
            chk("b2b_no_bubble", lows, 0);
            req = 1'b0;
            for (int i = 0; i < NB + 2; i++) cycle();
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req   = ($urandom_range(0, 15) == 0) || (i > 2000 && i < 2100);
            ready = ($urandom_range(0, 9) < 7);
            c0 = {$urandom, $urandom}; c1 = {$urandom, $urandom};
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
